apb_cmd_master: RTL
===================

// Module: apb_cmd_master
// PURPOSE
//  APB4 requester (initiator) driving the uart_apb responder's register bus.
//  Accepts one command per valid/ready handshake and runs one APB SETUP/ACCESS transfer.
//  Returns read data and error status on a valid/ready response channel.
//  Sits between the on-chip controller logic and the UART's in_p* port group.
// PARAMETERS
//  ADDR_W   32   APB address width (out_paddr)
//  DATA_W   32   APB data width; strobe width = DATA_W/8
//  TIMEOUT  255  max ACCESS cycles waiting for in_pready; 0 = no timeout
// PORTS
//  clk          in   1         clock, all logic on rising edge
//  reset        in   1         asynchronous, active-high reset
//  cmd_valid    in   1         command present
//  cmd_ready    out  1         command accepted when valid&ready
//  cmd_write    in   1         1 = write, 0 = read
//  cmd_addr     in   ADDR_W    transfer address
//  cmd_wdata    in   DATA_W    write data
//  cmd_strb     in   DATA_W/8  write byte strobes
//  cmd_prot     in   3         pprot value
//  rsp_valid    out  1         response present
//  rsp_ready    in   1         response consumed when valid&ready
//  rsp_rdata    out  DATA_W    read data (0 for writes, errors, timeouts)
//  rsp_err      out  1         pslverr seen or timeout
//  rsp_timeout  out  1         transfer aborted by timeout
//  out_psel     out  1         APB select
//  out_penable  out  1         APB enable
//  out_pprot    out  3         APB protection
//  out_paddr    out  ADDR_W    APB address
//  out_pwrite   out  1         APB direction
//  out_pwdata   out  DATA_W    APB write data
//  out_pstrb    out  DATA_W/8  APB strobes
//  in_pready    in   1         responder ready
//  in_prdata    in   DATA_W    responder read data
//  in_pslverr   in   1         responder error
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0 (cmd_ready is 0 during reset,
//    1 in the first cycle after release).
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch all cmd_* fields; go to SETUP.
//  - SETUP (1 cycle): psel=1, penable=0; drive paddr/pwrite/pprot/pwdata/pstrb from latched fields.
//  - ACCESS: psel=1, penable=1; address/control/data held stable until the transfer ends.
//  - ACCESS exits on the first cycle with in_pready=1:
//    sample in_pslverr; sample in_prdata only when the transfer is a read with pslverr=0.
//    rsp_rdata is 0 in every other case.
//  - Exit into RESP: psel=0 and penable=0 in the next cycle; there are no back-to-back APB transfers.
//  - Reads drive out_pstrb=0 and out_pwdata=0 (APB4 rule); cmd_strb is ignored for reads.
//  - Timeout counter, width $clog2(TIMEOUT+1):
//    cleared in SETUP, increments in each ACCESS cycle with in_pready=0.
//    When it reaches TIMEOUT (TIMEOUT!=0): abort to RESP with rsp_err=1, rsp_timeout=1,
//    rsp_rdata=0, psel/penable=0.
//    If in_pready=1 arrives in the same cycle, completion takes precedence over timeout.
//  - RESP: rsp_valid=1; rsp_* held stable until rsp_ready=1, then IDLE.
//    rsp_valid clears and cmd_ready sets in the next cycle.
//  - Throughput: at most one command per 4 cycles (accept, SETUP, ACCESS, RESP) with zero wait states.
//  - cmd_* inputs changing outside the accept cycle have no effect.
//  - reset asserted at any point: bus released (psel/penable=0) immediately and asynchronously;
//    the in-flight command is dropped and no response is issued.
// TESTING
//  - Write 0x0000_0004 <- 0xA5, strb=4'b0001, pready=1 at first ACCESS ->
//    psel high 2 cycles, penable 1 cycle, pstrb=0001; rsp_valid, err=0, rdata=0.
//  - Read 0x0000_0008, pready low 3 ACCESS cycles then high with prdata=0x1234_5678 ->
//    paddr stable 5 cycles, pstrb=0; rsp_rdata=0x1234_5678, err=0.
//  - Read with pslverr=1 on the completion cycle, prdata=0xFFFF_FFFF ->
//    rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  - TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles; psel drops;
//    rsp_err=1, rsp_timeout=1. Repeat with pready=1 on cycle 4 -> normal completion.
//  - rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0, new cmd_valid ignored;
//    that command is accepted 1 cycle after rsp_ready.
//  - reset pulsed mid-ACCESS -> psel/penable/rsp_valid=0 at once;
//    cmd_ready=1 the cycle after release; no response emitted.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Signal bundle between the command/response client, apb_cmd_master and the APB responder.
// Command, response and APB groups share one interface so the requester has a single bus port.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Valid/ready on both cmd and rsp: a beat transfers on a rising clock edge where
    // valid and ready are both high. The source holds valid and its payload stable
    // until that edge. valid never waits on ready; ready may depend on valid.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [2:0]        cmd_prot;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              out_psel;
    logic              out_penable;
    logic [2:0]        out_pprot;
    logic [ADDR_W-1:0] out_paddr;
    logic              out_pwrite;
    logic [DATA_W-1:0] out_pwdata;
    logic [STRB_W-1:0] out_pstrb;
    logic              in_pready;
    logic [DATA_W-1:0] in_prdata;
    logic              in_pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output out_psel, out_penable, out_pprot, out_paddr, out_pwrite, out_pwdata, out_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  out_psel, out_penable, out_pprot, out_paddr, out_pwrite, out_pwdata, out_pstrb,
        output in_pready, in_prdata, in_pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 requester: accepts one command, runs one SETUP/ACCESS transfer, returns one response.
// Every output is a flop; reset clears them asynchronously, releasing the bus at once.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    apb_cmd_master_if.master bus,
    output logic [1:0]       dbg_state
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam bit   TO_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [2:0]        pprot_q, pprot_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_hit;

    // The count holds the number of stalled ACCESS cycles already seen, so the
    // TIMEOUT-th stalled cycle is the one that finds cnt_q at TIMEOUT-1.
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pprot_d       = pprot_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    // The APB output flops double as the command latch.
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pprot_d     = bus.cmd_prot;
                    paddr_d     = bus.cmd_addr;
                    pwrite_d    = bus.cmd_write;
                    pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
                    pstrb_d     = bus.cmd_write ? bus.cmd_strb : '0;
                    state_d     = S_SETUP;
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (bus.in_pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.in_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !bus.in_pslverr) ? bus.in_prdata : '0;
                    state_d       = S_RESP;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pprot_q       <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pprot_q       <= pprot_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.out_psel    = psel_q;
    assign bus.out_penable = penable_q;
    assign bus.out_pprot   = pprot_q;
    assign bus.out_paddr   = paddr_q;
    assign bus.out_pwrite  = pwrite_q;
    assign bus.out_pwdata  = pwdata_q;
    assign bus.out_pstrb   = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign dbg_state       = state_q;
endmodule
